alu_result_fifo: RTL and testbench
==================================

# alu_result_fifo

Result buffer that sits directly downstream of the 32-bit ALU (`alu32`). It captures each ALU result together with its C/N/Z/V flags into a small FIFO and presents the entries to the consumer over a valid/ready handshake. It also keeps sticky carry and overflow status and counts entries dropped because the buffer was full. This decouples the combinational ALU from a slower writeback or checker stage.

## Interface
- `DEPTH`, 4: number of entries; power of two, minimum 2.
- `WIDTH`, 32: result width; matches the ALU datapath.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  the ALU output is a valid entry this cycle.
- `in_ready`  out  1  the buffer can accept an entry (not full).
- `in_result`  in  WIDTH  ALU result.
- `in_c`, `in_n`, `in_z`, `in_v`  in  1 each  ALU flags.
- `out_valid`  out  1  the head entry is valid.
- `out_ready`  in  1  the consumer takes the head entry.
- `out_result`  out  WIDTH  head result.
- `out_c`, `out_n`, `out_z`, `out_v`  out  1 each  head flags.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `sticky_c`, `sticky_v`  out  1 each  OR of `c`/`v` over all entries accepted since the last clear.
- `sticky_clr`  in  1  clears the sticky flags, `drop_err` and `drop_cnt`.
- `drop_err`  out  1  sticky: at least one entry was dropped.
- `drop_cnt`  out  8  number of dropped entries; saturates at 255.

## Operation
- **Push:** `in_valid && in_ready`. The entry {result, c, n, z, v} is written at `wr_ptr`; `wr_ptr` increments modulo DEPTH.
- **Pop:** `out_valid && out_ready`. `rd_ptr` increments modulo DEPTH.
- **Count:**
  - Push only: `count` increments.
  - Pop only: `count` decrements.
  - Push and pop in the same cycle: `count` is unchanged.
- **Output status:**
  - `in_ready = (count != DEPTH)`. It depends only on state; there is no combinational path from `out_ready`.
  - `out_valid = (count != 0)`.
  - The `out_*` data comes from a combinational read of `mem[rd_ptr]`.
- **Full:** when `count == DEPTH`, `in_ready` is low even if `out_ready` is high in the same cycle.
- **Drop:** the ALU cannot stall, so `in_valid && !in_ready` is a drop.
  - The entry is discarded.
  - `drop_err` is set to 1.
  - `drop_cnt` increments, saturating at 255.
- **Sticky flags:**
  - On a push, `sticky_c |= in_c` and `sticky_v |= in_v`.
  - `sticky_clr` zeroes `sticky_c`, `sticky_v`, `drop_err` and `drop_cnt`.
  - If `sticky_clr` coincides with a push, the result is `sticky_c = in_c` and `sticky_v = in_v`.
  - If `sticky_clr` coincides with a drop, the result is `drop_err = 1` and `drop_cnt = 1`.
- **Empty:** `out_*` data is don't-care while `out_valid` is 0. A pop request while empty has no effect.
- **Reset** (`reset == 0` at a rising edge), including mid-operation:
  - `wr_ptr`, `rd_ptr` and `count` return to 0.
  - `sticky_c`, `sticky_v`, `drop_err` and `drop_cnt` return to 0.
  - Consequently `in_ready = 1` and `out_valid = 0`.
  - Buffered entries are lost. Memory contents are not cleared.

## Timing
- Latency from push to visibility is 1 cycle: an entry pushed at edge k gives `out_valid = 1` with that data after edge k.
- Throughput is 1 push and 1 pop per cycle sustained when 0 < count < DEPTH.
- After a pop from a full buffer, `in_ready` rises the cycle after the pop edge.
- `count`, the sticky outputs, `drop_err` and `drop_cnt` are all registered outputs.
- Reset values: `in_ready = 1`, `out_valid = 0`, `count = 0`, sticky outputs 0, `drop_cnt = 0`.

## Structure
- The shared package `alu_pkg` holds:
  - `alu_flags_t` packed struct {c, n, z, v};
  - `alu_entry_t` {result[31:0], flags};
  - `ALU_W = 32`;
  - `DROP_CNT_W = 8`.
- One sub-module, `alu_result_fifo_mem`: a DEPTH x `alu_entry_t` register array with one write port and one asynchronous read port.
- Pointer, count and sticky logic stay in the top module.

## Test plan
- **Reset:** hold `reset = 0` for 2 cycles with `in_valid = 1`.
  - Expect `count = 0`, `out_valid = 0`, `in_ready = 1`, `drop_cnt = 0`, and no entry accepted.
- **Single entry:** push result 0x00000005 with flags c=0, n=0, z=0, v=0, and hold `out_ready = 0`.
  - One cycle later: `out_valid = 1`, `out_result = 0x00000005`, `count = 1`.
  - Then assert `out_ready = 1`: the next cycle gives `count = 0` and `out_valid = 0`.
- **Fill and drop:** with `out_ready = 0`, push 0x1, 0x2, 0x3, 0x4, 0x5.
  - After the fourth push: `count = 4`, `in_ready = 0`.
  - 0x5 is dropped: `drop_err = 1`, `drop_cnt = 1`.
  - Draining then yields 0x1, 0x2, 0x3, 0x4 in order.
- **Simultaneous push and pop with wrap:** at `count = 2`, push and pop every cycle for 8 cycles.
  - `count` stays at 2.
  - Outputs come in input order across the pointer wrap.
- **Sticky flags:** push an entry with c=1, v=0 (result 0x00000000 from 0xFFFFFFFF + 1), then an entry with c=0, v=1 (result 0x80000000).
  - Expect `sticky_c = 1` and `sticky_v = 1`.
  - Assert `sticky_clr` together with a push of c=0, v=1: expect `sticky_c = 0`, `sticky_v = 1`.
- **Reset mid-stream:** at `count = 3` with `drop_cnt = 2`, assert reset for 1 cycle.
  - All counters and flags read 0 and `out_valid = 0`.
  - The next push is output correctly with `count = 1`.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared ALU types: flag bundle and result-buffer entry.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_W      = 32;
    localparam int DROP_CNT_W = 8;

    typedef struct packed {
        logic c;
        logic n;
        logic z;
        logic v;
    } alu_flags_t;

    typedef struct packed {
        logic [ALU_W-1:0] result;
        alu_flags_t       flags;
    } alu_entry_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_result_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module   : alu_result_fifo_mem
//  Purpose  : DEPTH x alu_entry_t register array, one write port and one
//             asynchronous read port. Contents are never reset.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_result_fifo_mem
    import alu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  alu_entry_t        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output alu_entry_t        rd_data
);

    alu_entry_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule : alu_result_fifo_mem
`default_nettype wire

// File: rtl/alu_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : alu_result_fifo
//  Purpose  : Result buffer behind alu32: FIFO of {result, C/N/Z/V} with a
//             valid/ready output, sticky C/V status and a dropped-entry count.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ALU_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_result,
    input  logic                      in_c,
    input  logic                      in_n,
    input  logic                      in_z,
    input  logic                      in_v,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_result,
    output logic                      out_c,
    output logic                      out_n,
    output logic                      out_z,
    output logic                      out_v,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      sticky_c,
    output logic                      sticky_v,
    input  logic                      sticky_clr,
    output logic                      drop_err,
    output logic [DROP_CNT_W-1:0]     drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]      c_full     = CNT_W'(DEPTH);
    localparam logic [DROP_CNT_W-1:0] c_drop_max = '1;

    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_sticky_c;
    logic                  r_sticky_v;
    logic                  r_drop_err;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    logic       w_in_ready;
    logic       w_out_valid;
    logic       w_push;
    logic       w_pop;
    logic       w_drop;
    alu_entry_t w_wr_entry;
    alu_entry_t w_rd_entry;

    // Ready is purely a function of the occupancy register, so a full buffer
    // refuses input even when the consumer is popping in the same cycle.
    assign w_in_ready  = (r_count != c_full);
    assign w_out_valid = (r_count != '0);
    assign w_push      = in_valid && w_in_ready;
    assign w_pop       = w_out_valid && out_ready;
    assign w_drop      = in_valid && !w_in_ready;

    assign w_wr_entry.result  = in_result;
    assign w_wr_entry.flags.c = in_c;
    assign w_wr_entry.flags.n = in_n;
    assign w_wr_entry.flags.z = in_z;
    assign w_wr_entry.flags.v = in_v;

    alu_result_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (w_push),
        .wr_addr (r_wr_ptr),
        .wr_data (w_wr_entry),
        .rd_addr (r_rd_ptr),
        .rd_data (w_rd_entry)
    );

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A clear that coincides with a push/drop still records that event.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sticky_c <= 1'b0;
            r_sticky_v <= 1'b0;
            r_drop_err <= 1'b0;
            r_drop_cnt <= '0;
        end else if (sticky_clr) begin
            r_sticky_c <= w_push && in_c;
            r_sticky_v <= w_push && in_v;
            r_drop_err <= w_drop;
            r_drop_cnt <= w_drop ? DROP_CNT_W'(1) : '0;
        end else begin
            r_sticky_c <= r_sticky_c | (w_push && in_c);
            r_sticky_v <= r_sticky_v | (w_push && in_v);
            r_drop_err <= r_drop_err | w_drop;
            if (w_drop && (r_drop_cnt != c_drop_max)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = w_out_valid;
    assign out_result = w_rd_entry.result;
    assign out_c      = w_rd_entry.flags.c;
    assign out_n      = w_rd_entry.flags.n;
    assign out_z      = w_rd_entry.flags.z;
    assign out_v      = w_rd_entry.flags.v;
    assign count      = r_count;
    assign sticky_c   = r_sticky_c;
    assign sticky_v   = r_sticky_v;
    assign drop_err   = r_drop_err;
    assign drop_cnt   = r_drop_cnt;

endmodule : alu_result_fifo
`default_nettype wire

// File: tb/tb_alu_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_result_fifo
//  Purpose  : Directed scoreboard bench for alu_result_fifo.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_result_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_c, in_n, in_z, in_v;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_c, out_n, out_z, out_v;
    logic [2:0]  count;
    logic        sticky_c, sticky_v;
    logic        sticky_clr;
    logic        drop_err;
    logic [7:0]  drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected entries: {result, c, n, z, v}
    logic [35:0] sb[$];

    alu_result_fifo #(.DEPTH(4), .WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_c       (in_c),
        .in_n       (in_n),
        .in_z       (in_z),
        .in_v       (in_v),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_c      (out_c),
        .out_n      (out_n),
        .out_z      (out_z),
        .out_v      (out_v),
        .count      (count),
        .sticky_c   (sticky_c),
        .sticky_v   (sticky_v),
        .sticky_clr (sticky_clr),
        .drop_err   (drop_err),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // flags ordered {c, n, z, v}
    task automatic push(input logic [31:0] r, input logic [3:0] f, input bit accept);
        in_valid  = 1'b1;
        in_result = r;
        {in_c, in_n, in_z, in_v} = f;
        if (accept) sb.push_back({r, f});
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain(input int cycles);
        out_ready = 1'b1;
        repeat (cycles) step();
        out_ready = 1'b0;
    endtask

    // Monitor: a pop happens at the next rising edge whenever valid && ready.
    always @(negedge clk) begin
        if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: got 0x%0h expected no entry", out_result);
            end else begin
                logic [35:0] exp_e;
                exp_e = sb.pop_front();
                if ({out_result, out_c, out_n, out_z, out_v} !== exp_e) begin
                    n_fail++;
                    $display("FAIL pop_data: got 0x%0h expected 0x%0h",
                             {out_result, out_c, out_n, out_z, out_v}, exp_e);
                end
            end
        end
    end

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_result = '0;
        {in_c, in_n, in_z, in_v} = 4'b0;
        out_ready = 1'b0; sticky_clr = 1'b0;

        // Reset held with in_valid asserted
        #1;
        in_valid = 1'b1; in_result = 32'hDEAD_BEEF;
        step(); step();
        reset = 1'b1; in_valid = 1'b0;
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("rst_sticky", 32'({sticky_c, sticky_v, drop_err}), 32'd0);

        // Single entry
        push(32'h0000_0005, 4'b0000, 1'b1);
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_result", out_result, 32'h0000_0005);
        check("single_count", 32'(count), 32'd1);
        drain(1);
        check("single_count_after", 32'(count), 32'd0);
        check("single_valid_after", 32'(out_valid), 32'd0);

        // Pop while empty has no effect
        drain(1);
        check("empty_pop_count", 32'(count), 32'd0);

        // Fill and drop
        for (int i = 1; i <= 4; i++) push(32'(i), 4'b0000, 1'b1);
        check("fill_count", 32'(count), 32'd4);
        check("fill_in_ready", 32'(in_ready), 32'd0);
        push(32'h5, 4'b0000, 1'b0);
        check("drop_err", 32'(drop_err), 32'd1);
        check("drop_cnt", 32'(drop_cnt), 32'd1);
        check("drop_count", 32'(count), 32'd4);
        out_ready = 1'b1;
        step();
        check("full_pop_in_ready", 32'(in_ready), 32'd1);
        check("full_pop_count", 32'(count), 32'd3);
        drain(3);
        check("drain_count", 32'(count), 32'd0);

        // Simultaneous push/pop across pointer wrap
        push(32'h10, 4'b0000, 1'b1);
        push(32'h11, 4'b0100, 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push(32'h12 + 32'(i), 4'(i), 1'b1);
            check("pp_count", 32'(count), 32'd2);
        end
        drain(2);
        check("pp_drain_count", 32'(count), 32'd0);

        // Sticky flags
        sticky_clr = 1'b1; step(); sticky_clr = 1'b0;
        check("clr_drop_err", 32'(drop_err), 32'd0);
        check("clr_drop_cnt", 32'(drop_cnt), 32'd0);
        check("clr_sticky", 32'({sticky_c, sticky_v}), 32'd0);
        push(32'h0000_0000, 4'b1010, 1'b1);  // FFFFFFFF + 1
        check("sticky_c_only", 32'({sticky_c, sticky_v}), 32'b10);
        push(32'h8000_0000, 4'b0101, 1'b1);  // 7FFFFFFF + 1
        check("sticky_cv", 32'({sticky_c, sticky_v}), 32'b11);
        sticky_clr = 1'b1;
        push(32'h8000_0000, 4'b0101, 1'b1);
        sticky_clr = 1'b0;
        check("clr_with_push", 32'({sticky_c, sticky_v}), 32'b01);
        push(32'h0000_0007, 4'b0000, 1'b1);
        check("sticky_count", 32'(count), 32'd4);
        sticky_clr = 1'b1;
        push(32'h0000_0008, 4'b1001, 1'b0);
        sticky_clr = 1'b0;
        check("clr_with_drop", 32'({sticky_c, sticky_v, drop_err}), 32'b001);
        check("clr_with_drop_cnt", 32'(drop_cnt), 32'd1);
        push(32'h0000_0009, 4'b0000, 1'b0);
        drain(1);
        check("pre_reset_count", 32'(count), 32'd3);
        check("pre_reset_drop_cnt", 32'(drop_cnt), 32'd2);

        // Reset mid-stream
        reset = 1'b0;
        sb.delete();
        step();
        reset = 1'b1;
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_drop", 32'({drop_cnt, drop_err, sticky_c, sticky_v}), 32'd0);
        push(32'h0000_ABCD, 4'b0010, 1'b1);
        check("post_rst_count", 32'(count), 32'd1);
        check("post_rst_result", out_result, 32'h0000_ABCD);
        drain(1);

        // Drop counter saturation
        for (int i = 0; i < 4; i++) push(32'h100 + 32'(i), 4'b0000, 1'b1);
        in_valid = 1'b1;
        repeat (260) step();
        in_valid = 1'b0;
        check("sat_drop_cnt", 32'(drop_cnt), 32'd255);
        check("sat_drop_err", 32'(drop_err), 32'd1);
        drain(4);
        check("final_count", 32'(count), 32'd0);

        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d entries expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_alu_result_fifo
`default_nettype wire
